// File: rtl/gaussian_blur_writer.sv
// 3x3 Gaussian blur (1 2 1 / 2 4 2 / 1 2 1, /16) from a sync source memory into a column-major frame buffer.
// Optional BLUR_BYPASS_EN adds a `bypass` input that passes the centre tap through unmodified.
module gaussian_blur_writer #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef BLUR_BYPASS_EN
  input  logic              bypass,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_mem_address,
  input  logic [23:0]       src_mem_q,
  output logic [ADDR_W-1:0] wr_mem_address,
  output logic [23:0]       wr_mem_data,
  output logic              wr_a_pixel
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [3:0]        tap_q, tap_d;
  logic [11:0]       sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              wr_stb_q, wr_stb_d;
`ifdef BLUR_BYPASS_EN
  logic              bypass_q, bypass_d;
  logic [23:0]       centre_q, centre_d;
`endif

  logic [3:0]        acc_tap;
  logic [11:0]       add_r, add_g, add_b;
  logic [XW-1:0]     nx;
  logic [YW-1:0]     ny;

  // Tap t = (dy+1)*3 + (dx+1); neighbours past the edge replicate the edge pixel.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [XW-1:0] px,
                                                 input logic [YW-1:0] py,
                                                 input logic [3:0]    t);
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [1:0]    col, row;
    case (t)
      4'd0, 4'd1, 4'd2: row = 2'd0;
      4'd3, 4'd4, 4'd5: row = 2'd1;
      default:          row = 2'd2;
    endcase
    case (t)
      4'd0, 4'd3, 4'd6: col = 2'd0;
      4'd1, 4'd4, 4'd7: col = 2'd1;
      default:          col = 2'd2;
    endcase
    cx = px;
    if (col == 2'd0 && px != '0)         cx = px - 1'b1;
    else if (col == 2'd2 && px != X_MAX) cx = px + 1'b1;
    cy = py;
    if (row == 2'd0 && py != '0)         cy = py - 1'b1;
    else if (row == 2'd2 && py != Y_MAX) cy = py + 1'b1;
    return ADDR_W'(cy) + ADDR_W'(cx) * ADDR_W'(IMG_H);
  endfunction

  function automatic logic [11:0] weigh(input logic [7:0] c, input logic [3:0] t);
    case (t)
      4'd4:                   return {2'b00, c, 2'b00};
      4'd1, 4'd3, 4'd5, 4'd7: return {3'b000, c, 1'b0};
      default:                return {4'b0000, c};
    endcase
  endfunction

  function automatic logic [7:0] round16(input logic [11:0] s);
    logic [11:0] t;
    t = s + 12'd8;
    return t[11:4];
  endfunction

  // Read data lags the address by one cycle, so FETCH accumulates the previous tap and DRAIN the last.
  assign acc_tap = (state_q == S_DRAIN) ? 4'd8 : tap_q - 4'd1;
  assign add_r   = sum_r_q + weigh(src_mem_q[23:16], acc_tap);
  assign add_g   = sum_g_q + weigh(src_mem_q[15:8],  acc_tap);
  assign add_b   = sum_b_q + weigh(src_mem_q[7:0],   acc_tap);

  always_comb begin
    nx = x_q;
    ny = y_q + 1'b1;
    if (y_q == Y_MAX) begin
      ny = '0;
      nx = x_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    tap_d      = tap_q;
    sum_r_d    = sum_r_q;
    sum_g_d    = sum_g_q;
    sum_b_d    = sum_b_q;
    src_addr_d = src_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_stb_d   = 1'b0;
`ifdef BLUR_BYPASS_EN
    bypass_d   = bypass_q;
    centre_d   = centre_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          x_d        = '0;
          y_d        = '0;
          tap_d      = '0;
          src_addr_d = tap_addr('0, '0, 4'd0);
`ifdef BLUR_BYPASS_EN
          bypass_d   = bypass;
`endif
        end
      end
      S_FETCH: begin
        if (tap_q == 4'd0) begin
          sum_r_d = '0;
          sum_g_d = '0;
          sum_b_d = '0;
        end else begin
          sum_r_d = add_r;
          sum_g_d = add_g;
          sum_b_d = add_b;
        end
`ifdef BLUR_BYPASS_EN
        if (tap_q == 4'd5) centre_d = src_mem_q;
`endif
        if (tap_q == 4'd8) begin
          state_d = S_DRAIN;
        end else begin
          tap_d      = tap_q + 4'd1;
          src_addr_d = tap_addr(x_q, y_q, tap_q + 4'd1);
        end
      end
      S_DRAIN: begin
        sum_r_d   = add_r;
        sum_g_d   = add_g;
        sum_b_d   = add_b;
        wr_data_d = {round16(add_r), round16(add_g), round16(add_b)};
`ifdef BLUR_BYPASS_EN
        if (bypass_q) wr_data_d = centre_q;
`endif
        wr_addr_d = ADDR_W'(y_q) + ADDR_W'(x_q) * ADDR_W'(IMG_H);
        wr_stb_d  = 1'b1;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        tap_d = '0;
        if (x_q == X_MAX && y_q == Y_MAX) begin
          state_d = S_DONE;
        end else begin
          x_d        = nx;
          y_d        = ny;
          src_addr_d = tap_addr(nx, ny, 4'd0);
          state_d    = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      tap_q      <= '0;
      sum_r_q    <= '0;
      sum_g_q    <= '0;
      sum_b_q    <= '0;
      src_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_stb_q   <= 1'b0;
`ifdef BLUR_BYPASS_EN
      bypass_q   <= 1'b0;
      centre_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      tap_q      <= tap_d;
      sum_r_q    <= sum_r_d;
      sum_g_q    <= sum_g_d;
      sum_b_q    <= sum_b_d;
      src_addr_q <= src_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_stb_q   <= wr_stb_d;
`ifdef BLUR_BYPASS_EN
      bypass_q   <= bypass_d;
      centre_q   <= centre_d;
`endif
    end
  end

  assign busy            = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign done            = (state_q == S_DONE);
  assign src_mem_address = src_addr_q;
  assign wr_mem_address  = wr_addr_q;
  assign wr_mem_data     = wr_data_q;
  assign wr_a_pixel      = wr_stb_q;

endmodule
